stream_arb2: RTL and testbench

//  Two-input round-robin stream arbiter with a registered output stage.

---
 rtl/stream_arb2_if.sv | 26 ++
 rtl/stream_arb2.sv | 110 +++++++++++
 tb/tb_stream_arb2.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/stream_arb2_if.sv
// Bundle of the two source streams and the merged output stream of stream_arb2.
// master: the arbiter's view. slave: the view of the logic around it.
interface stream_arb2_if #(
  parameter int unsigned WIDTH = 8
);
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             out_src;

  modport master (
    input  a_valid, a_data, b_valid, b_data, out_ready,
    output a_ready, b_ready, out_valid, out_data, out_src
  );

  modport slave (
    output a_valid, a_data, b_valid, b_data, out_ready,
    input  a_ready, b_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/stream_arb2.sv
// Two-input round-robin stream arbiter with a registered output stage.
// Each grant lasts at most BURST_MAX beats; every output beat carries its source tag.
module stream_arb2 #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned BURST_MAX = 4
) (
  input logic           clk,
  input logic           rst,
  stream_arb2_if.master bus
);
  localparam int unsigned   CW      = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] CntLast = CW'(BURST_MAX - 1);

  typedef enum logic [1:0] {StIdle, StGrantA, StGrantB} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             last_src_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_src_q;

  logic can_load;
  logic a_ready, b_ready;
  logic xfer_a, xfer_b;
  logic end_a, end_b;

  // Handshake decode; readies depend only on state and the output register, never on valids.
  always_comb begin
    can_load = !out_valid_q || bus.out_ready;
    a_ready  = (state_q == StGrantA) && can_load;
    b_ready  = (state_q == StGrantB) && can_load;
    xfer_a   = bus.a_valid && a_ready;
    xfer_b   = bus.b_valid && b_ready;
    end_a    = (xfer_a && (cnt_q == CntLast)) || !bus.a_valid;
    end_b    = (xfer_b && (cnt_q == CntLast)) || !bus.b_valid;
  end

  assign bus.a_ready   = a_ready;
  assign bus.b_ready   = b_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;

  // Grant FSM with burst counter and round-robin history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      last_src_q <= 1'b1;  // A wins the first tie
    end else begin
      if (xfer_a) begin
        last_src_q <= 1'b0;
      end else if (xfer_b) begin
        last_src_q <= 1'b1;
      end
      case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (bus.a_valid && bus.b_valid) begin
            state_q <= last_src_q ? StGrantA : StGrantB;
          end else if (bus.a_valid) begin
            state_q <= StGrantA;
          end else if (bus.b_valid) begin
            state_q <= StGrantB;
          end
        end
        StGrantA: begin
          if (end_a) begin
            cnt_q   <= '0;
            state_q <= bus.b_valid ? StGrantB : (bus.a_valid ? StGrantA : StIdle);
          end else begin
            cnt_q <= cnt_q + CW'(xfer_a);
          end
        end
        StGrantB: begin
          if (end_b) begin
            cnt_q   <= '0;
            state_q <= bus.a_valid ? StGrantA : (bus.b_valid ? StGrantB : StIdle);
          end else begin
            cnt_q <= cnt_q + CW'(xfer_b);
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Output register: load on a transfer, drain when the sink takes the held beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
    end else if (xfer_a) begin
      out_valid_q <= 1'b1;
      out_data_q  <= bus.a_data;
      out_src_q   <= 1'b0;
    end else if (xfer_b) begin
      out_valid_q <= 1'b1;
      out_data_q  <= bus.b_data;
      out_src_q   <= 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_stream_arb2.sv
// Directed bench for stream_arb2: one instance with BURST_MAX=4, one with BURST_MAX=1.
module tb_stream_arb2;
  logic clk;
  logic rst;

  int n_checks;
  int n_fail;
  int a_idx;
  int b_idx;
  bit auto_data;

  stream_arb2_if #(.WIDTH(8)) bus4 ();
  stream_arb2_if #(.WIDTH(8)) bus1 ();

  stream_arb2 #(.WIDTH(8), .BURST_MAX(4)) u_arb4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  stream_arb2 #(.WIDTH(8), .BURST_MAX(1)) u_arb1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock on bus4; with auto_data set, a source advances its data after an accepted beat.
  task automatic step4();
    logic xa, xb;
    #1;
    xa = bus4.a_valid && bus4.a_ready;
    xb = bus4.b_valid && bus4.b_ready;
    tick();
    if (auto_data && xa) begin
      a_idx++;
      bus4.a_data = 8'(8'hA0 + a_idx);
    end
    if (auto_data && xb) begin
      b_idx++;
      bus4.b_data = 8'(8'hB0 + b_idx);
    end
  endtask

  task automatic check_beat(input string tag, input logic [7:0] data, input logic src);
    check_eq({tag, "_valid"}, {31'd0, bus4.out_valid}, 32'd1);
    check_eq({tag, "_data"}, {24'd0, bus4.out_data}, {24'd0, data});
    check_eq({tag, "_src"}, {31'd0, bus4.out_src}, {31'd0, src});
  endtask

  logic [7:0] t3_data [12];
  logic       t3_src  [12];
  logic [7:0] t4_data [4];
  logic       t4_src  [4];
  logic [7:0] t6_data [5];
  logic       t6_src  [5];

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    a_idx     = 0;
    b_idx     = 0;
    auto_data = 1'b0;
    t3_data = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3,
                8'hA4, 8'hA5, 8'hA6, 8'hA7};
    t3_src  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    t4_data = '{8'hB5, 8'hB6, 8'hB7, 8'hA8};
    t4_src  = '{1'b1, 1'b1, 1'b1, 1'b0};
    t6_data = '{8'hB8, 8'hB9, 8'hBA, 8'hBB, 8'hAA};
    t6_src  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    rst = 1'b1;
    bus4.a_valid = 1'b0; bus4.a_data = '0; bus4.b_valid = 1'b0; bus4.b_data = '0;
    bus4.out_ready = 1'b0;
    bus1.a_valid = 1'b0; bus1.a_data = '0; bus1.b_valid = 1'b0; bus1.b_data = '0;
    bus1.out_ready = 1'b0;
    #2;
    check_eq("rst_out_valid", {31'd0, bus4.out_valid}, 32'd0);
    check_eq("rst_out_data", {24'd0, bus4.out_data}, 32'd0);
    check_eq("rst_out_src", {31'd0, bus4.out_src}, 32'd0);
    check_eq("rst_a_ready", {31'd0, bus4.a_ready}, 32'd0);
    check_eq("rst_b_ready", {31'd0, bus4.b_ready}, 32'd0);
    check_eq("rst1_out_valid", {31'd0, bus1.out_valid}, 32'd0);
    tick();
    rst = 1'b0;

    // T2: single source A, two beats, 1 cycle arbitration + 1 cycle latency
    bus4.out_ready = 1'b1;
    bus4.a_valid   = 1'b1;
    bus4.a_data    = 8'h11;
    #1;
    check_eq("t2_a_ready_idle", {31'd0, bus4.a_ready}, 32'd0);
    step4();
    check_eq("t2_a_ready_grant", {31'd0, bus4.a_ready}, 32'd1);
    check_eq("t2_out_valid_pre", {31'd0, bus4.out_valid}, 32'd0);
    step4();
    check_beat("t2_beat0", 8'h11, 1'b0);
    bus4.a_data = 8'h22;
    step4();
    check_beat("t2_beat1", 8'h22, 1'b0);
    bus4.a_valid = 1'b0;
    step4();
    check_eq("t2_drain", {31'd0, bus4.out_valid}, 32'd0);

    // T1: reset asserted while a beat is held
    bus4.a_valid = 1'b1;
    bus4.a_data  = 8'h33;
    step4();
    step4();
    check_beat("t1_held", 8'h33, 1'b0);
    rst = 1'b1;
    #1;
    check_eq("t1_out_valid", {31'd0, bus4.out_valid}, 32'd0);
    check_eq("t1_out_data", {24'd0, bus4.out_data}, 32'd0);
    check_eq("t1_a_ready", {31'd0, bus4.a_ready}, 32'd0);
    check_eq("t1_b_ready", {31'd0, bus4.b_ready}, 32'd0);

    // T3: both sources always valid, A wins the first tie after reset
    auto_data    = 1'b1;
    a_idx        = 0;
    b_idx        = 0;
    bus4.a_data  = 8'hA0;
    bus4.b_data  = 8'hB0;
    bus4.b_valid = 1'b1;
    step4();
    rst = 1'b0;
    step4();
    check_eq("t3_arb_valid", {31'd0, bus4.out_valid}, 32'd0);
    check_eq("t3_arb_a_ready", {31'd0, bus4.a_ready}, 32'd1);
    check_eq("t3_arb_b_ready", {31'd0, bus4.b_ready}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      step4();
      check_beat($sformatf("t3_beat%0d", i), t3_data[i], t3_src[i]);
    end

    // T4: backpressure for 3 cycles one beat into B's burst
    step4();
    check_beat("t4_first", 8'hB4, 1'b1);
    bus4.out_ready = 1'b0;
    #1;
    check_eq("t4_b_ready_stall", {31'd0, bus4.b_ready}, 32'd0);
    check_eq("t4_a_ready_stall", {31'd0, bus4.a_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step4();
      check_beat($sformatf("t4_hold%0d", i), 8'hB4, 1'b1);
    end
    bus4.out_ready = 1'b1;
    #1;
    check_eq("t4_b_ready_resume", {31'd0, bus4.b_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step4();
      check_beat($sformatf("t4_beat%0d", i), t4_data[i], t4_src[i]);
    end

    // T6: A drops valid after its second beat; B then gets a full burst
    step4();
    check_beat("t6_a2", 8'hA9, 1'b0);
    bus4.a_valid = 1'b0;
    step4();
    check_eq("t6_gap_valid", {31'd0, bus4.out_valid}, 32'd0);
    check_eq("t6_b_ready", {31'd0, bus4.b_ready}, 32'd1);
    check_eq("t6_a_ready", {31'd0, bus4.a_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step4();
      check_beat($sformatf("t6_beat%0d", i), t6_data[i], t6_src[i]);
      if (i == 0) bus4.a_valid = 1'b1;
    end
    bus4.a_valid = 1'b0;
    bus4.b_valid = 1'b0;

    // T5: BURST_MAX=1 alternates every beat; from IDLE the other source wins the tie
    bus1.out_ready = 1'b1;
    bus1.a_valid   = 1'b1;
    bus1.b_valid   = 1'b1;
    bus1.a_data    = 8'h5A;
    bus1.b_data    = 8'h5B;
    tick();
    check_eq("t5_arb_valid", {31'd0, bus1.out_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("t5_src%0d", i), {31'd0, bus1.out_src}, {31'd0, i[0]});
      check_eq($sformatf("t5_data%0d", i), {24'd0, bus1.out_data},
               (i[0] ? 32'h5B : 32'h5A));
    end
    bus1.a_valid = 1'b0;
    bus1.b_valid = 1'b0;
    tick();
    check_eq("t5_idle_valid", {31'd0, bus1.out_valid}, 32'd0);
    bus1.a_valid = 1'b1;
    bus1.b_valid = 1'b1;
    tick();
    check_eq("t5_rearb_b_ready", {31'd0, bus1.b_ready}, 32'd1);
    check_eq("t5_rearb_a_ready", {31'd0, bus1.a_ready}, 32'd0);
    tick();
    check_eq("t5_rearb_src", {31'd0, bus1.out_src}, 32'd1);
    check_eq("t5_rearb_data", {24'd0, bus1.out_data}, 32'h5B);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
